// File: rtl/onewire_responder.sv
// Single-wire open-drain bus responder.
// Presence on bus reset, command receive, scratch byte write/read.
module onewire_responder #(
  parameter int RESET_MIN     = 480,
  parameter int PRESENCE_WAIT = 30,
  parameter int PRESENCE_LEN  = 120,
  parameter int SAMPLE_AT     = 15,
  parameter int ZERO_HOLD     = 30,
  parameter int CNT_W         = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bus_in,
  output logic       bus_pull_low,
  output logic       cmd_valid,
  output logic [7:0] cmd,
  output logic [7:0] scratch,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, PRES_WAIT, PRES_DRIVE, CMD_RX, WR_RX, RD_TX
  } state_t;

  localparam logic [CNT_W-1:0] RST_LIM = CNT_W'(RESET_MIN);
  localparam logic [CNT_W-1:0] PW_END  = CNT_W'(PRESENCE_WAIT - 1);
  localparam logic [CNT_W-1:0] PL_END  = CNT_W'(PRESENCE_LEN - 1);
  localparam logic [CNT_W-1:0] SMP_PT  = CNT_W'(SAMPLE_AT);
  localparam logic [CNT_W-1:0] HLD_END = CNT_W'(ZERO_HOLD);

  state_t           state, state_n;
  logic             s1, bs, bs_d;
  logic [2:0]       pl_hist;
  logic [CNT_W-1:0] low_cnt, cnt, cnt_n;
  logic [2:0]       bit_cnt, bit_n;
  logic             slot_act, slot_n;
  logic [7:0]       sh, sh_n, cmd_n, scratch_n, rx_byte;
  logic             pull_n, cmd_valid_n;
  logic             own, fall, rise, fall_ok, rst_pulse, last_bit;

  // Our own drive (and its echo through the synchroniser) is masked.
  assign own       = bus_pull_low | (|pl_hist);
  assign fall      = bs_d & ~bs;
  assign rise      = ~bs_d & bs;
  assign fall_ok   = fall & ~own;
  assign rst_pulse = rise & (low_cnt == RST_LIM);
  assign last_bit  = (bit_cnt == 3'd7);
  assign rx_byte   = {bs, sh[7:1]};
  assign busy      = (state != IDLE);

  // Wire synchroniser, drive history and saturating low counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1      <= 1'b1;
      bs      <= 1'b1;
      bs_d    <= 1'b1;
      pl_hist <= '0;
      low_cnt <= '0;
    end else begin
      s1      <= bus_in;
      bs      <= s1;
      bs_d    <= bs;
      pl_hist <= {pl_hist[1:0], bus_pull_low};
      if (bs || own)
        low_cnt <= '0;
      else if (low_cnt != RST_LIM)
        low_cnt <= low_cnt + 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      slot_act     <= 1'b0;
      sh           <= '0;
      cmd          <= '0;
      scratch      <= '0;
      bus_pull_low <= 1'b0;
      cmd_valid    <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      bit_cnt      <= bit_n;
      slot_act     <= slot_n;
      sh           <= sh_n;
      cmd          <= cmd_n;
      scratch      <= scratch_n;
      bus_pull_low <= pull_n;
      cmd_valid    <= cmd_valid_n;
    end
  end

  // Next-state, slot timing and output decode.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bit_n       = bit_cnt;
    slot_n      = slot_act;
    sh_n        = sh;
    cmd_n       = cmd;
    scratch_n   = scratch;
    pull_n      = bus_pull_low;
    cmd_valid_n = 1'b0;
    unique case (state)
      IDLE: begin
        pull_n = 1'b0;
        slot_n = 1'b0;
        bit_n  = '0;
      end
      PRES_WAIT: begin
        cnt_n = cnt + 1'b1;
        if (cnt == PW_END) begin
          state_n = PRES_DRIVE;
          cnt_n   = '0;
          pull_n  = 1'b1;
        end
      end
      PRES_DRIVE: begin
        cnt_n = cnt + 1'b1;
        if (cnt == PL_END) begin
          state_n = CMD_RX;
          cnt_n   = '0;
          pull_n  = 1'b0;
          bit_n   = '0;
          slot_n  = 1'b0;
        end
      end
      CMD_RX, WR_RX: begin
        if (!slot_act) begin
          if (fall_ok) begin
            slot_n = 1'b1;
            cnt_n  = CNT_W'(1);
          end
        end else begin
          cnt_n = cnt + 1'b1;
          if (cnt == SMP_PT) begin
            slot_n = 1'b0;
            sh_n   = rx_byte;
            bit_n  = bit_cnt + 1'b1;
            if (last_bit && state == CMD_RX) begin
              cmd_n       = rx_byte;
              cmd_valid_n = 1'b1;
              if (rx_byte == 8'h4E) begin
                state_n = WR_RX;
              end else if (rx_byte == 8'hBE) begin
                state_n = RD_TX;
                sh_n    = scratch;
              end else begin
                state_n = IDLE;
              end
            end else if (last_bit) begin
              scratch_n = rx_byte;
              state_n   = IDLE;
            end
          end
        end
      end
      RD_TX: begin
        if (!slot_act) begin
          if (fall_ok) begin
            slot_n = 1'b1;
            cnt_n  = CNT_W'(1);
            pull_n = ~sh[0];
          end
        end else begin
          cnt_n = cnt + 1'b1;
          if (cnt == HLD_END) begin
            pull_n = 1'b0;
            slot_n = 1'b0;
            sh_n   = {1'b0, sh[7:1]};
            bit_n  = bit_cnt + 1'b1;
            if (last_bit)
              state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        pull_n  = 1'b0;
      end
    endcase
    if (rst_pulse) begin
      state_n = PRES_WAIT;
      cnt_n   = '0;
      bit_n   = '0;
      slot_n  = 1'b0;
      pull_n  = 1'b0;
    end
  end

endmodule

// File: tb/tb_onewire_responder.sv
// Directed bench for onewire_responder.
// Models the bus master and the wired-AND wire.
module tb_onewire_responder;

  localparam int PW = 30;
  localparam int PL = 120;

  logic       clk = 1'b0;
  logic       rst;
  logic       m_low;
  wire        bus_in;
  logic       bus_pull_low;
  logic       cmd_valid;
  logic [7:0] cmd;
  logic [7:0] scratch;
  logic       busy;

  int         n_vec = 0;
  int         n_bad = 0;
  int         cv_cnt = 0;
  logic [7:0] cv_cmd = 8'h00;
  int         pull_cyc = 0;

  assign bus_in = ~(m_low | bus_pull_low);

  always #5 clk = ~clk;

  onewire_responder dut (
    .clk          (clk),
    .rst          (rst),
    .bus_in       (bus_in),
    .bus_pull_low (bus_pull_low),
    .cmd_valid    (cmd_valid),
    .cmd          (cmd),
    .scratch      (scratch),
    .busy         (busy)
  );

  // Record command pulses and count driven cycles.
  always @(negedge clk) begin
    if (cmd_valid) begin
      cv_cnt = cv_cnt + 1;
      cv_cmd = cmd;
    end
    if (bus_pull_low)
      pull_cyc = pull_cyc + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic low_pulse(input int n);
    m_low = 1'b1;
    repeat (n) tick();
    m_low = 1'b0;
  endtask

  task automatic wr_bit(input logic b);
    m_low = 1'b1;
    repeat (b ? 5 : 60) tick();
    m_low = 1'b0;
    repeat (b ? 65 : 10) tick();
  endtask

  task automatic wr_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) wr_bit(v[i]);
  endtask

  task automatic rd_bit(output logic b);
    m_low = 1'b1;
    repeat (4) tick();
    m_low = 1'b0;
    repeat (11) tick();
    b = bus_in;
    repeat (55) tick();
  endtask

  task automatic rd_byte(output logic [7:0] v);
    logic b;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      rd_bit(b);
      v[i] = b;
    end
  endtask

  // Reset pulse, then measure presence delay and width.
  // Delay = 2 sync + 1 edge detect + PW count.
  task automatic reset_presence(input string tag, input int len);
    int n;
    int w;
    low_pulse(len);
    n = 0;
    while (!bus_pull_low && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_dly"}, n, PW + 3);
    check({tag, "_busy"}, {31'd0, busy}, 1);
    w = 0;
    while (bus_pull_low && w < 300) begin
      tick();
      w++;
    end
    check({tag, "_len"}, w, PL);
    repeat (20) tick();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] r;
    logic       b;
    int         p0;
    int         c0;
    rst   = 1'b1;
    m_low = 1'b0;
    repeat (3) tick();
    check("rst_pull", {31'd0, bus_pull_low}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_cv", {31'd0, cmd_valid}, 0);
    check("rst_cmd", {24'd0, cmd}, 8'h00);
    check("rst_scr", {24'd0, scratch}, 8'h00);
    rst = 1'b0;
    repeat (5) tick();

    reset_presence("t1", 500);
    repeat (50) tick();
    check("t1_busy_rx", {31'd0, busy}, 1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    p0 = pull_cyc;
    low_pulse(479);
    repeat (100) tick();
    check("t2_nopres", pull_cyc - p0, 0);
    check("t2_idle", {31'd0, busy}, 0);

    c0 = cv_cnt;
    reset_presence("t3", 480);
    wr_byte(8'h4E);
    check("t3_cv_cnt", cv_cnt - c0, 1);
    check("t3_cv_cmd", {24'd0, cv_cmd}, 8'h4E);
    check("t3_busy_wr", {31'd0, busy}, 1);
    wr_byte(8'hA5);
    check("t3_scr", {24'd0, scratch}, 8'hA5);
    check("t3_cmd", {24'd0, cmd}, 8'h4E);
    check("t3_idle", {31'd0, busy}, 0);

    reset_presence("t4", 500);
    wr_byte(8'hBE);
    check("t4_cmd", {24'd0, cmd}, 8'hBE);
    rd_byte(r);
    check("t4_rd", {24'd0, r}, 8'hA5);
    check("t4_idle", {31'd0, busy}, 0);

    reset_presence("t5", 500);
    wr_byte(8'h33);
    check("t5_cv_cmd", {24'd0, cv_cmd}, 8'h33);
    check("t5_idle", {31'd0, busy}, 0);
    p0 = pull_cyc;
    wr_byte(8'hFF);
    wr_byte(8'h00);
    check("t5_scr", {24'd0, scratch}, 8'hA5);
    check("t5_rel", pull_cyc - p0, 0);

    reset_presence("t6", 500);
    wr_byte(8'h4E);
    for (int i = 0; i < 4; i++) wr_bit(1'b1);
    reset_presence("t6b", 500);
    check("t6_scr", {24'd0, scratch}, 8'hA5);
    wr_byte(8'hBE);
    rd_bit(b);
    check("t6_bit0", {31'd0, b}, 1);
    m_low = 1'b1;
    repeat (8) tick();
    check("t6_drive", {31'd0, bus_pull_low}, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_rel", {31'd0, bus_pull_low}, 0);
    check("t6_async_busy", {31'd0, busy}, 0);
    check("t6_async_scr", {24'd0, scratch}, 8'h00);
    check("t6_async_cmd", {24'd0, cmd}, 8'h00);
    m_low = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
